io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Parametrised memory-mapped I/O block.
- Replaces the single fixed 4-bit in/out pair hard-wired into the datapath.
- Provides N_PORTS ports of IO_W bits each, with:
  - two-flop input synchronisers;
  - registered outputs;
  - per-port edge capture with mask;
  - a combined interrupt line.
- Sits on the data-memory side of the datapath: driven by the DAR address, MDR write data and the dmem write enable; feeds the MDR input mux.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 10, address width (matches DAR).
- IO_W, 4, bits per port; must be <= DATA_W.
- N_PORTS, 2, number of ports, 1..16.
- BASE_ADDR, 10'h3C0, window base; must be aligned to 4*N_PORTS rounded up to a power of two.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- addr  in  ADDR_W  access address.
- w_en  in  1  write strobe.
- r_en  in  1  read strobe.
- d_in  in  DATA_W  write data.
- hit  out  1  combinational; addr lies inside the window.
- d_out  out  DATA_W  registered read data.
- rd_valid  out  1  d_out holds the data of the previous cycle's read.
- io_in  in  N_PORTS*IO_W  external inputs, asynchronous; port p uses bits [p*IO_W +: IO_W].
- io_out  out  N_PORTS*IO_W  registered outputs, same packing as io_in.
- irq  out  1  OR over all ports of (edge_status & edge_mask).

Behaviour:
- Register map, port p, offset = addr - BASE_ADDR:
  - 4p+0 IN: read-only, synchronised input; writes ignored.
  - 4p+1 OUT: read/write output register.
  - 4p+2 EDGE: status; write-1-to-clear.
  - 4p+3 MASK: read/write edge interrupt mask.
- hit = (BASE_ADDR <= addr < BASE_ADDR + 4*N_PORTS).
- Width rules:
  - Reads zero-extend IO_W to DATA_W.
  - Writes use d_in[IO_W-1:0]; upper bits ignored.
- Writes: take effect at the rising edge where w_en & hit. No effect when hit=0.
- Reads, 1-cycle latency:
  - r_en & hit at edge k → d_out = register value before edge k's writes, and rd_valid=1 after edge k.
  - Otherwise rd_valid=0 and d_out=0.
- Simultaneous r_en and w_en to the same register: read returns the old value.
- Synchroniser: sync1 <= io_in; sync2 <= sync1. IN reads return sync2. An io_in change is readable via a read issued after 2 edges.
- Edge detect:
  - prev <= sync2.
  - Without the optional feature: rise = sync2 & ~prev.
  - edge_status <= (edge_status & ~clr) | rise, where clr = d_in bits on a write to EDGE.
  - A newly detected edge wins over a simultaneous clear of the same bit.
  - Status bits are set at the 3rd rising edge after an io_in change.
- irq: combinational from edge_status & edge_mask. Asserts the same cycle status sets (if masked in). Deasserts the cycle after clear or mask-off.
- Reset (rst=1 at an edge) clears: io_out, edge_status, edge_mask, sync1, sync2, prev, d_out, rd_valid. irq is therefore 0.
- Reset mid-access: any in-flight read is dropped (rd_valid=0). Writes in the reset cycle are ignored.
- No edges are captured in the first 2 cycles after reset, because sync and prev start equal at 0.

Optional Feature:
- IO_PORT_BANK_BOTH_EDGE_EN
- Defined: capture term = sync2 ^ prev, so both rising and falling edges set EDGE status.
- Undefined: rising edges only.
- Register map and latency are identical in both builds.

Test Plan:
- Reset, then read all 4*N_PORTS offsets → every read has rd_valid=1 and d_out=0x00; irq=0.
- Write 0xA5 to 0x3C1 (port0 OUT) → io_out[3:0]=4'h5 next cycle; read 0x3C1 returns 0x05. Write 0x0C to 0x3C5 → io_out[7:4]=4'hC.
- Drive io_in[3:0]=4'b0011 → IN 0x3C0 reads 0x00 until 2 edges have passed, 0x03 after. EDGE 0x3C2 reads 0x03 from the 3rd edge.
- Edge interrupt sequence:
  - Mask 0x3C3=0x01, then rising edge on io_in[0] → irq=1 at edge 3.
  - Write 0x01 to 0x3C2 → irq=0 next cycle.
  - Repeat with clear coinciding with a new edge detection → status stays 1, irq stays 1.
- Address 0x3BF and 0x3C8 (outside window, N_PORTS=2) → hit=0; writes leave io_out unchanged; r_en gives rd_valid=0.
- Assert rst mid-stream with io_out=0xFF and status nonzero → all outputs 0 after that edge. With IO_PORT_BANK_BOTH_EDGE_EN, a falling edge 1→0 on io_in[1] sets EDGE bit1; without the macro it does not.

Source files
------------

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of N_PORTS I/O ports (IN/OUT/EDGE/MASK)
// with two-flop input synchronisers, registered outputs, masked edge capture
// and one combined interrupt. Define IO_PORT_BANK_BOTH_EDGE_EN to capture
// falling as well as rising edges.
// Ports: clk, rst (sync, active-high); addr/w_en/r_en/d_in bus side;
// hit (comb window decode); d_out/rd_valid (1-cycle read); io_in (async),
// io_out (registered); irq (OR of status & mask).
module io_port_bank #(
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 10,
  parameter int          IO_W      = 4,
  parameter int          N_PORTS   = 2,
  parameter int unsigned BASE_ADDR = 32'h3C0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [DATA_W-1:0]       d_in,
  output logic                    hit,
  output logic [DATA_W-1:0]       d_out,
  output logic                    rd_valid,
  input  logic [N_PORTS*IO_W-1:0] io_in,
  output logic [N_PORTS*IO_W-1:0] io_out,
  output logic                    irq
);

  localparam int PW = N_PORTS * IO_W;
  localparam logic [31:0] WIN_LO = BASE_ADDR;
  localparam logic [31:0] WIN_HI =
    BASE_ADDR + 32'(4 * N_PORTS);

  logic [31:0]   addr_ext;
  logic [31:0]   off;
  logic [29:0]   port_sel;
  logic [1:0]    reg_sel;

  logic [PW-1:0] sync1;
  logic [PW-1:0] sync2;
  logic [PW-1:0] prev;
  logic [PW-1:0] out_q;
  logic [PW-1:0] status_q;
  logic [PW-1:0] mask_q;

  logic [PW-1:0] out_nx;
  logic [PW-1:0] mask_nx;
  logic [PW-1:0] clr;
  logic [PW-1:0] cap;
  logic [PW-1:0] status_nx;
  logic [IO_W-1:0] rd_word;

  logic [DATA_W-1:0] d_out_q;
  logic              rd_valid_q;

  // Only the low IO_W bits of write data reach any register.
  logic unused_d_in;
  assign unused_d_in = ^d_in;

  // Window decode in 32 bits so BASE + size never wraps.
  assign addr_ext = 32'(addr);
  assign hit      = (addr_ext >= WIN_LO)
                 && (addr_ext <  WIN_HI);
  assign off      = addr_ext - WIN_LO;
  assign port_sel = off[31:2];
  assign reg_sel  = off[1:0];

  // Register-file access: read mux and write decode.
  always_comb begin
    out_nx  = out_q;
    mask_nx = mask_q;
    clr     = '0;
    rd_word = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (hit && (port_sel == 30'(p))) begin
        unique case (reg_sel)
          2'd0: begin
            rd_word = sync2[p*IO_W +: IO_W];
          end
          2'd1: begin
            rd_word = out_q[p*IO_W +: IO_W];
            if (w_en)
              out_nx[p*IO_W +: IO_W] =
                d_in[IO_W-1:0];
          end
          2'd2: begin
            rd_word = status_q[p*IO_W +: IO_W];
            if (w_en)
              clr[p*IO_W +: IO_W] =
                d_in[IO_W-1:0];
          end
          2'd3: begin
            rd_word = mask_q[p*IO_W +: IO_W];
            if (w_en)
              mask_nx[p*IO_W +: IO_W] =
                d_in[IO_W-1:0];
          end
        endcase
      end
    end
  end

  // Capture term; OR-ing it after the clear lets a fresh
  // edge win over a simultaneous write-1-to-clear.
  always_comb begin
`ifdef IO_PORT_BANK_BOTH_EDGE_EN
    cap = sync2 ^ prev;
`else
    cap = sync2 & ~prev;
`endif
    status_nx = (status_q & ~clr) | cap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      out_q      <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      d_out_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sync1      <= io_in;
      sync2      <= sync1;
      prev       <= sync2;
      out_q      <= out_nx;
      status_q   <= status_nx;
      mask_q     <= mask_nx;
      rd_valid_q <= r_en && hit;
      if (r_en && hit)
        d_out_q <= DATA_W'(rd_word);
      else
        d_out_q <= '0;
    end
  end

  assign io_out   = out_q;
  assign d_out    = d_out_q;
  assign rd_valid = rd_valid_q;
  assign irq      = |(status_q & mask_q);

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed self-checking bench for io_port_bank.
// Read expectations go through a queue and are popped when d_out is valid.
module tb_io_port_bank;

`ifdef IO_PORT_BANK_BOTH_EDGE_EN
  localparam logic [7:0] FALL_EXP = 8'h03;
`else
  localparam logic [7:0] FALL_EXP = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] addr = '0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] d_in = '0;
  logic       hit;
  logic [7:0] d_out;
  logic       rd_valid;
  logic [7:0] io_in = '0;
  logic [7:0] io_out;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .w_en     (w_en),
    .r_en     (r_en),
    .d_in     (d_in),
    .hit      (hit),
    .d_out    (d_out),
    .rd_valid (rd_valid),
    .io_in    (io_in),
    .io_out   (io_out),
    .irq      (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a,
                    input logic [7:0] d);
    addr = a;
    d_in = d;
    w_en = 1'b1;
    r_en = 1'b0;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a,
                    input logic [7:0] e,
                    input string tag);
    addr = a;
    r_en = 1'b1;
    w_en = 1'b0;
    exp_q.push_back(e);
    tick();
    r_en = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    if (exp_q.size() > 0)
      chk(tag, 32'(d_out), 32'(exp_q.pop_front()));
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_vld", 32'(rd_valid), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_out", 32'(io_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    for (int i = 0; i < 8; i++)
      rd(10'h3C0 + 10'(i), 8'h00, "rst_map");
    chk("map_irq", 32'(irq), 32'd0);

    // OUT registers
    wr(10'h3C1, 8'hA5);
    chk("out0", 32'(io_out[3:0]), 32'h5);
    chk("wr_novld", 32'(rd_valid), 32'd0);
    rd(10'h3C1, 8'h05, "rd_out0");
    wr(10'h3C5, 8'h0C);
    chk("out1", 32'(io_out), 32'hC5);

    // Read and write same register in one cycle
    addr = 10'h3C1;
    d_in = 8'h0A;
    w_en = 1'b1;
    r_en = 1'b1;
    exp_q.push_back(8'h05);
    tick();
    w_en = 1'b0;
    r_en = 1'b0;
    chk("rw_vld", 32'(rd_valid), 32'd1);
    chk("rw_old", 32'(d_out), 32'(exp_q.pop_front()));
    chk("rw_new", 32'(io_out), 32'hCA);

    // Synchroniser latency and rising-edge capture
    io_in = 8'h03;
    rd(10'h3C0, 8'h00, "in_e1");
    rd(10'h3C0, 8'h00, "in_e2");
    rd(10'h3C0, 8'h03, "in_e3");
    rd(10'h3C2, 8'h03, "edge_set");
    chk("nomask_irq", 32'(irq), 32'd0);
    wr(10'h3C2, 8'h03);
    rd(10'h3C2, 8'h00, "edge_clr");

    // Falling edges: captured only in the both-edge build
    io_in = 8'h00;
    for (int i = 0; i < 4; i++)
      tick();
    rd(10'h3C2, FALL_EXP, "edge_fall");
    wr(10'h3C2, 8'h03);
    rd(10'h3C2, 8'h00, "fall_clr");

    // Masked interrupt
    wr(10'h3C3, 8'h01);
    io_in = 8'h01;
    tick();
    chk("irq_e1", 32'(irq), 32'd0);
    tick();
    chk("irq_e2", 32'(irq), 32'd0);
    tick();
    chk("irq_e3", 32'(irq), 32'd1);
    wr(10'h3C2, 8'h01);
    chk("irq_clr", 32'(irq), 32'd0);

    // Clear coinciding with a new edge detection
    io_in = 8'h00;
    for (int i = 0; i < 4; i++)
      tick();
    wr(10'h3C2, 8'h01);
    chk("irq_idle", 32'(irq), 32'd0);
    io_in = 8'h01;
    tick();
    tick();
    wr(10'h3C2, 8'h01);
    chk("race_irq", 32'(irq), 32'd1);
    rd(10'h3C2, 8'h01, "race_edge");
    chk("race_hold", 32'(irq), 32'd1);
    wr(10'h3C3, 8'h00);
    chk("maskoff", 32'(irq), 32'd0);
    rd(10'h3C2, 8'h01, "st_kept");

    // Window boundaries
    addr = 10'h3BF;
    #1;
    chk("hit_lo", 32'(hit), 32'd0);
    addr = 10'h3C8;
    #1;
    chk("hit_hi", 32'(hit), 32'd0);
    addr = 10'h3C0;
    #1;
    chk("hit_first", 32'(hit), 32'd1);
    addr = 10'h3C7;
    #1;
    chk("hit_last", 32'(hit), 32'd1);
    wr(10'h3BF, 8'hFF);
    chk("oow_wr_lo", 32'(io_out), 32'hCA);
    wr(10'h3C8, 8'hFF);
    chk("oow_wr_hi", 32'(io_out), 32'hCA);
    addr = 10'h3BF;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("oow_rd_lo", 32'(rd_valid), 32'd0);
    chk("oow_d_lo", 32'(d_out), 32'd0);
    addr = 10'h3C8;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("oow_rd_hi", 32'(rd_valid), 32'd0);

    // Reset in the middle of traffic
    wr(10'h3C1, 8'h0F);
    wr(10'h3C5, 8'hFF);
    chk("pre_out", 32'(io_out), 32'hFF);
    wr(10'h3C3, 8'h01);
    chk("pre_irq", 32'(irq), 32'd1);
    io_in = 8'h00;
    rst = 1'b1;
    addr = 10'h3C1;
    d_in = 8'h05;
    r_en = 1'b1;
    w_en = 1'b1;
    tick();
    rst = 1'b0;
    r_en = 1'b0;
    w_en = 1'b0;
    chk("mrst_out", 32'(io_out), 32'd0);
    chk("mrst_vld", 32'(rd_valid), 32'd0);
    chk("mrst_dout", 32'(d_out), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    rd(10'h3C3, 8'h00, "mrst_mask");
    rd(10'h3C2, 8'h00, "mrst_edge");
    rd(10'h3C1, 8'h00, "mrst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
